// File: rtl/bp_me_axi_pkg.sv
// Shared configuration, FSM state encodings and AXI constant encodings for the
// cache-DMA to AXI4 burst bridge.
package bp_me_axi_pkg;

  localparam int daddr_width_gp    = 40;
  localparam int l2_fill_width_gp  = 64;
  localparam int l2_block_width_gp = 512;
  localparam logic [daddr_width_gp-1:0] dram_base_addr_gp = 40'h00_8000_0000;

  localparam logic [1:0] axi_burst_incr_gp    = 2'b01;
  localparam logic [2:0] axi_prot_default_gp  = 3'b011;
  localparam logic [3:0] axi_cache_default_gp = 4'b0011;

  typedef enum logic {e_rd_idle, e_rd_data} rd_state_e;
  typedef enum logic {e_wr_idle, e_wr_data} wr_state_e;

  typedef struct packed {
    logic                      write_not_read;
    logic [daddr_width_gp-1:0] addr;
  } bp_cache_dma_pkt_s;

endpackage

// File: rtl/bp_me_dram_hash_decode.sv
// Undoes the L2 bank hash on a DRAM address. With a single slice and bank the
// hash is the identity, so the decode is a pass-through.
module bp_me_dram_hash_decode #(
  parameter int daddr_width_p = 40
) (
  input  logic [daddr_width_p-1:0] daddr_i,
  output logic [daddr_width_p-1:0] daddr_o
);

  assign daddr_o = daddr_i;

endmodule

// File: rtl/bsg_counter_clear_up.sv
// Up counter with a clear that may coincide with an increment (clear wins,
// then the increment is applied to zero).
module bsg_counter_clear_up #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               clear_i,
  input  logic               up_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)      count_o <= '0;
    else if (clear_i) count_o <= width_p'(up_i);
    else if (up_i)    count_o <= count_o + width_p'(1);
  end

endmodule

// File: rtl/bsg_counter_up_down.sv
// Up/down counter; simultaneous up and down leave the count unchanged.
module bsg_counter_up_down #(
  parameter int width_p = 3
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) count_o <= '0;
    else         count_o <= count_o + width_p'(up_i) - width_p'(down_i);
  end

endmodule

// File: rtl/bp_cache_dma_to_axi4_burst.sv
// bsg_cache DMA (packet / fill / evict) to AXI4 manager, one INCR burst per
// cache block, with sticky read/write error flags.
//
//   state     | meaning
//   e_rd_idle | waiting for a read packet; AR offered with the packet
//   e_rd_data | forwarding R beats to the fill channel until the last beat
//   e_wr_idle | waiting for a write packet and a free outstanding slot
//   e_wr_data | forwarding evict data as W beats until wlast
module bp_cache_dma_to_axi4_burst
  import bp_me_axi_pkg::*;
#(
  parameter int axi_addr_width_p     = 28,
  parameter int axi_data_width_p     = 64,
  parameter int axi_id_width_p       = 1,
  parameter int max_wr_outstanding_p = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,

  output logic [axi_addr_width_p-1:0]   araddr_o,
  output logic [7:0]                    arlen_o,
  output logic [2:0]                    arsize_o,
  output logic [1:0]                    arburst_o,
  output logic [axi_id_width_p-1:0]     arid_o,
  output logic [2:0]                    arprot_o,
  output logic [3:0]                    arcache_o,
  output logic                          arvalid_o,
  input  logic                          arready_i,

  input  logic [axi_data_width_p-1:0]   rdata_i,
  input  logic [1:0]                    rresp_i,
  input  logic                          rlast_i,
  input  logic [axi_id_width_p-1:0]     rid_i,
  input  logic                          rvalid_i,
  output logic                          rready_o,

  output logic [axi_addr_width_p-1:0]   awaddr_o,
  output logic [7:0]                    awlen_o,
  output logic [2:0]                    awsize_o,
  output logic [1:0]                    awburst_o,
  output logic [axi_id_width_p-1:0]     awid_o,
  output logic [2:0]                    awprot_o,
  output logic [3:0]                    awcache_o,
  output logic                          awvalid_o,
  input  logic                          awready_i,

  output logic [axi_data_width_p-1:0]   wdata_o,
  output logic [axi_data_width_p/8-1:0] wstrb_o,
  output logic                          wlast_o,
  output logic                          wvalid_o,
  input  logic                          wready_i,

  input  logic [1:0]                    bresp_i,
  input  logic [axi_id_width_p-1:0]     bid_i,
  input  logic                          bvalid_i,
  output logic                          bready_o,

  input  logic [$bits(bp_cache_dma_pkt_s)-1:0] dma_pkt_i,
  input  logic                          dma_pkt_v_i,
  output logic                          dma_pkt_yumi_o,

  output logic [l2_fill_width_gp-1:0]   dma_data_o,
  output logic                          dma_data_v_o,
  input  logic                          dma_data_ready_and_i,

  input  logic [l2_fill_width_gp-1:0]   dma_data_i,
  input  logic                          dma_data_v_i,
  output logic                          dma_data_yumi_o,

  output logic                          rd_error_o,
  output logic                          wr_error_o
);

  localparam int beats_lp          = l2_block_width_gp / axi_data_width_p;
  localparam int lg_beats_lp       = $clog2(beats_lp);
  localparam int axi_strb_width_lp = axi_data_width_p / 8;
  localparam int block_offset_lp   = $clog2(l2_block_width_gp / 8);
  localparam int lg_wr_out_lp      = $clog2(max_wr_outstanding_p + 1);

  bp_cache_dma_pkt_s dma_pkt;
  assign dma_pkt = dma_pkt_i;

  logic [daddr_width_gp-1:0]   hashed_addr, dram_addr;
  logic [axi_addr_width_p-1:0] axi_addr;

  bp_me_dram_hash_decode #(.daddr_width_p(daddr_width_gp)) hash_decode (
    .daddr_i (dma_pkt.addr),
    .daddr_o (hashed_addr)
  );

  assign dram_addr = hashed_addr ^ dram_base_addr_gp;
  assign axi_addr  = {dram_addr[axi_addr_width_p-1:block_offset_lp], block_offset_lp'(0)};

  assign araddr_o  = axi_addr;
  assign arlen_o   = 8'(beats_lp - 1);
  assign arsize_o  = 3'($clog2(axi_strb_width_lp));
  assign arburst_o = axi_burst_incr_gp;
  assign arid_o    = '0;
  assign arprot_o  = axi_prot_default_gp;
  assign arcache_o = axi_cache_default_gp;

  assign awaddr_o  = axi_addr;
  assign awlen_o   = 8'(beats_lp - 1);
  assign awsize_o  = 3'($clog2(axi_strb_width_lp));
  assign awburst_o = axi_burst_incr_gp;
  assign awid_o    = '0;
  assign awprot_o  = axi_prot_default_gp;
  assign awcache_o = axi_cache_default_gp;

  assign wstrb_o    = '1;
  assign wdata_o    = dma_data_i;
  assign dma_data_o = rdata_i;
  assign bready_o   = 1'b1;

  // ---------------- read channel ----------------
  rd_state_e              rd_state_r, rd_state_n;
  logic [lg_beats_lp-1:0] rd_count;
  logic                   rd_clear, rd_pkt_yumi, rd_last, r_hs;

  assign rd_last = (rd_count == lg_beats_lp'(beats_lp - 1));
  assign r_hs    = (rd_state_r == e_rd_data) & rvalid_i & dma_data_ready_and_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rd_state_r <= e_rd_idle;
    else         rd_state_r <= rd_state_n;
  end

  // arvalid is gated by reset so a packet held during reset is never offered
  always_comb begin
    rd_state_n   = rd_state_r;
    arvalid_o    = 1'b0;
    rd_pkt_yumi  = 1'b0;
    rd_clear     = 1'b0;
    rready_o     = 1'b0;
    dma_data_v_o = 1'b0;
    case (rd_state_r)
      e_rd_idle: begin
        arvalid_o = ~reset_i & dma_pkt_v_i & ~dma_pkt.write_not_read;
        if (arvalid_o & arready_i) begin
          rd_pkt_yumi = 1'b1;
          rd_clear    = 1'b1;
          rd_state_n  = e_rd_data;
        end
      end
      e_rd_data: begin
        dma_data_v_o = rvalid_i;
        rready_o     = dma_data_ready_and_i;
        if (r_hs & rd_last) rd_state_n = e_rd_idle;
      end
      default: rd_state_n = e_rd_idle;
    endcase
  end

  bsg_counter_clear_up #(.width_p(lg_beats_lp)) rd_beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (rd_clear),
    .up_i    (r_hs),
    .count_o (rd_count)
  );

  // ---------------- write channel ----------------
  wr_state_e              wr_state_r, wr_state_n;
  logic [lg_beats_lp-1:0] wr_count;
  logic [lg_wr_out_lp-1:0] wr_outstanding;
  logic                   wr_clear, wr_pkt_yumi, wr_last, wr_slot_free, aw_hs, b_hs;

  assign wr_last      = (wr_count == lg_beats_lp'(beats_lp - 1));
  assign wr_slot_free = (wr_outstanding < lg_wr_out_lp'(max_wr_outstanding_p));

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wr_state_r <= e_wr_idle;
    else         wr_state_r <= wr_state_n;
  end

  always_comb begin
    wr_state_n      = wr_state_r;
    awvalid_o       = 1'b0;
    wr_pkt_yumi     = 1'b0;
    wr_clear        = 1'b0;
    wvalid_o        = 1'b0;
    wlast_o         = 1'b0;
    dma_data_yumi_o = 1'b0;
    case (wr_state_r)
      e_wr_idle: begin
        awvalid_o = ~reset_i & dma_pkt_v_i & dma_pkt.write_not_read & wr_slot_free;
        if (awvalid_o & awready_i) begin
          wr_pkt_yumi = 1'b1;
          wr_clear    = 1'b1;
          wr_state_n  = e_wr_data;
        end
      end
      e_wr_data: begin
        wvalid_o        = dma_data_v_i;
        wlast_o         = wr_last;
        dma_data_yumi_o = wvalid_o & wready_i;
        if (dma_data_yumi_o & wr_last) wr_state_n = e_wr_idle;
      end
      default: wr_state_n = e_wr_idle;
    endcase
  end

  assign aw_hs = awvalid_o & awready_i;
  assign b_hs  = bvalid_i & bready_o;

  bsg_counter_clear_up #(.width_p(lg_beats_lp)) wr_beat_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .clear_i (wr_clear),
    .up_i    (dma_data_yumi_o),
    .count_o (wr_count)
  );

  // an unsolicited B must not wrap the count below zero
  bsg_counter_up_down #(.width_p(lg_wr_out_lp)) wr_outstanding_counter (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (aw_hs),
    .down_i  (b_hs & (wr_outstanding != '0)),
    .count_o (wr_outstanding)
  );

  assign dma_pkt_yumi_o = dma_pkt.write_not_read ? wr_pkt_yumi : rd_pkt_yumi;

  // ---------------- sticky error flags ----------------
  logic rd_error_r, wr_error_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_error_r <= 1'b0;
      wr_error_r <= 1'b0;
    end else begin
      if (r_hs & (rresp_i[1] | (rlast_i != rd_last)))
        rd_error_r <= 1'b1;
      if (b_hs & (bresp_i[1] | (wr_outstanding == '0)))
        wr_error_r <= 1'b1;
    end
  end

  assign rd_error_o = rd_error_r;
  assign wr_error_o = wr_error_r;

  // IDs are always 0 and only the error bit of each response matters
  logic unused_bits;
  assign unused_bits = ^{dram_addr[daddr_width_gp-1:axi_addr_width_p],
                         dram_addr[block_offset_lp-1:0],
                         rid_i, bid_i, rresp_i[0], bresp_i[0]};

endmodule

// File: doc/bp_cache_dma_to_axi4_burst.md
# bp_cache_dma_to_axi4_burst

Converts a bsg_cache DMA interface (packet, fill-data, evict-data channels) into a full AXI4 manager issuing one INCR burst per cache block. Parametrised in block width, AXI data width, ID width and number of outstanding writes. Adds rlast/rresp/bresp error checking. Sits between the L2 cache DMA port and the board DRAM controller AXI slave port.

## Interface
- bp_params_p, e_bp_default_cfg: BlackParrot config; provides daddr_width_p, l2_fill_width_p, l2_block_width_p, dram_base_addr_gp.
- axi_addr_width_p, 28: AXI address width.
- axi_data_width_p, 64: AXI data width; must equal l2_fill_width_p.
- axi_id_width_p, 1: AXI ID width; all transactions use ID 0.
- max_wr_outstanding_p, 4: bursts awaiting B response; at least 1.
- Derived: beats_lp = l2_block_width_p/axi_data_width_p (8 at defaults), lg_beats_lp, axi_strb_width_lp = axi_data_width_p/8.

Ports. One clock; reset is asynchronous and active-high.
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous active-high reset.
- araddr_o/arlen_o/arsize_o/arburst_o/arid_o/arprot_o/arcache_o  out  addr/8/3/2/id/3/4  AR payload.
- arvalid_o out 1; arready_i in 1.
- rdata_i in data; rresp_i in 2; rlast_i in 1; rid_i in id; rvalid_i in 1; rready_o out 1.
- awaddr_o/awlen_o/awsize_o/awburst_o/awid_o/awprot_o/awcache_o  out  as for AR.
- awvalid_o out 1; awready_i in 1.
- wdata_o out data; wstrb_o out strb; wlast_o out 1; wvalid_o out 1; wready_i in 1.
- bresp_i in 2; bid_i in id; bvalid_i in 1; bready_o out 1.
- dma_pkt_i in dma_pkt_width; dma_pkt_v_i in 1; dma_pkt_yumi_o out 1.
- dma_data_o out fill; dma_data_v_o out 1; dma_data_ready_and_i in 1: read fill data.
- dma_data_i in fill; dma_data_v_i in 1; dma_data_yumi_o out 1: evict data.
- rd_error_o, wr_error_o  out  1  sticky error flags.

## Operation
- Address: dma_pkt.addr passes through bp_me_dram_hash_decode, then XOR with dram_base_addr_gp, then truncated to axi_addr_width_p and aligned down to a block boundary.
- Constant fields: len = beats_lp-1; size = clog2(axi_strb_width_lp); burst = 2'b01 (INCR); id = 0; prot = 3'b011; cache = 4'b0011; wstrb all ones.
- Packet routing: write_not_read selects the FSM. dma_pkt_yumi_o = read yumi or write yumi, depending on that bit.
- Read FSM: e_rd_idle, e_rd_data.
  - e_rd_idle: arvalid_o = dma_pkt_v_i & read. On arready_i, yumi the packet, clear the beat counter and go to e_rd_data.
  - e_rd_data: dma_data_o = rdata_i; dma_data_v_o = rvalid_i; rready_o = dma_data_ready_and_i. Each handshake increments the beat counter. On the beat where count == beats_lp-1, return to e_rd_idle.
  - One read is outstanding at a time.
- Write FSM: e_wr_idle, e_wr_data.
  - e_wr_idle: awvalid_o = dma_pkt_v_i & write & (outstanding < max_wr_outstanding_p). On awready_i, yumi the packet and go to e_wr_data.
  - e_wr_data: wvalid_o = dma_data_v_i; wdata_o = dma_data_i; wlast_o = (count == beats_lp-1); dma_data_yumi_o = wvalid_o & wready_i. After the last beat, go to e_wr_idle.
- Outstanding counter: +1 on AW handshake, -1 on B handshake; both in one cycle leaves it unchanged. bready_o is constant 1.
- rd_error set by R handshake with rresp_i[1]; also by rlast_i mismatching (count == beats_lp-1).
- wr_error set by B handshake with bresp_i[1]; also by bvalid_i when the outstanding count is 0.
- Errors are sticky until reset and never stall the FSMs.

## Timing
- Reset (async assert, synchronous release): FSMs idle, counters 0, errors 0.
- During reset: all valids, yumis and rready_o are 0; bready_o is 1.
- AR/AW are issued in the same cycle the packet is presented if the channel is idle. Packet yumi is combinational on arready_i/awready_i.
- No AXI-side registering, so zero added latency on R and W data.
- Read and write FSMs run concurrently. A write blocked at max outstanding stalls only write packets.
- valid never depends on ready, per AXI. dma_pkt_i must hold stable while valid.
- Reset mid-burst abandons the burst; the surrounding system must also reset the AXI slave.

## Structure
- rd/wr state enums belong in bp_me_axi_pkg; so do the constant encodings (INCR, prot, cache).
- Sub-modules:
  - bsg_counter_clear_up: beat counters.
  - bsg_counter_up_down: outstanding writes.
  - bp_me_dram_hash_decode: address.
- No new sub-module.

## Test plan
- Read at DMA addr 0x8000_0040: AR with araddr = decoded^base, arlen 7, arsize 3, arburst 1. 8 R beats forwarded in order; idle after the rlast beat.
- Write with wready toggling 1/0: 8 W beats; wlast only on beat 7; 8 data yumis; B OKAY leaves wr_error 0.
- Back-to-back writes, bvalid held 0: exactly 4 AW issued, 5th packet not yumi'd. One B releases it the next cycle.
- Concurrent read and write packets: both bursts complete correctly and independently. dma_pkt_yumi_o fires for the selected type only.
- Error cases, each raising its flag, which stays high until reset:
  - rresp 2'b10 on beat 3 sets rd_error_o.
  - rlast at beat 5 sets rd_error_o.
  - bresp 2'b11 sets wr_error_o.
  - Unsolicited bvalid sets wr_error_o.
- Assert reset_i asynchronously mid-write: outputs go to reset values immediately; the next read completes normally.
